// File: rtl/dct_rle_encoder.sv
// Run-length sequencer for MPEG-2 intra AC coefficients: counts zero runs, drives the
// (run, |level|) VLC lookup and emits right-aligned VLC+sign, 24-bit escape or EOB tokens.
module dct_rle_encoder #(
  parameter int unsigned CoeffW = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     coeff_valid_i,
  output logic                     coeff_ready_o,
  input  logic signed [CoeffW-1:0] coeff_i,
  input  logic                     coeff_last_i,
  output logic [5:0]               vlc_run_o,
  output logic [15:0]              vlc_level_o,
  input  logic [15:0]              vlc_code_i,
  input  logic [3:0]               vlc_len_i,
  input  logic                     vlc_escape_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [23:0]              out_bits_o,
  output logic [4:0]               out_len_o,
  output logic                     block_done_o
);

  localparam logic [23:0] EobBits = 24'h000006;
  localparam logic [4:0]  EobLen  = 5'd4;

  typedef enum logic [1:0] {StScan, StLookup, StEmit, StEob} state_e;

  state_e        state_q, state_d;
  logic [5:0]    run_q, run_d;
  logic [5:0]    vlc_run_q, vlc_run_d;
  logic [15:0]   vlc_level_q, vlc_level_d;
  logic          sign_q, sign_d;
  logic          last_q, last_d;
  logic [11:0]   esc_lvl_q, esc_lvl_d;
  logic [23:0]   bits_q, bits_d;
  logic [4:0]    len_q, len_d;
  logic          done_q, done_d;

  logic               accept, out_fire, coeff_nz;
  logic signed [31:0] coeff_ext;
  logic [15:0]        abs_val;
  logic [11:0]        lvl12;
  logic [4:0]         vlc_l;
  logic [23:0]        vlc_bits, esc_bits;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScan: begin
        if (coeff_valid_i) begin
          if (coeff_i != '0)     state_d = StLookup;
          else if (coeff_last_i) state_d = StEob;
        end
      end
      StLookup: state_d = StEmit;
      StEmit:   if (out_ready_i) state_d = last_q ? StEob : StScan;
      StEob:    if (out_ready_i) state_d = StScan;
      default:  state_d = StScan;
    endcase
  end

  // FSM outputs
  always_comb begin
    coeff_ready_o = (state_q == StScan);
    out_valid_o   = (state_q == StEmit) || (state_q == StEob);
  end

  assign accept   = coeff_ready_o && coeff_valid_i;
  assign out_fire = out_valid_o && out_ready_i;
  assign coeff_nz = (coeff_i != '0);

  // Escape carries a 12-bit signed level clamped to +/-2047; lookup sees the raw magnitude
  always_comb begin
    coeff_ext = 32'(coeff_i);
    abs_val   = coeff_ext[31] ? 16'(-coeff_ext) : 16'(coeff_ext);
    if (coeff_ext > 32'sd2047)       lvl12 = 12'h7ff;
    else if (coeff_ext < -32'sd2047) lvl12 = 12'h801;
    else                             lvl12 = coeff_ext[11:0];
  end

  always_comb begin
    vlc_l    = (vlc_len_i == 4'd0) ? 5'd16 : {1'b0, vlc_len_i};
    vlc_bits = '0;
    vlc_bits[0] = sign_q;
    for (int i = 0; i < 16; i++) begin
      vlc_bits[i+1] = vlc_code_i[i] & (5'(i) < vlc_l);
    end
    esc_bits = {6'b000001, vlc_run_q, esc_lvl_q};
  end

  always_comb begin
    run_d       = run_q;
    vlc_run_d   = vlc_run_q;
    vlc_level_d = vlc_level_q;
    sign_d      = sign_q;
    last_d      = last_q;
    esc_lvl_d   = esc_lvl_q;
    bits_d      = bits_q;
    len_d       = len_q;
    done_d      = (state_q == StEob) && out_ready_i;

    if (accept) begin
      if (coeff_nz) begin
        vlc_run_d   = run_q;
        vlc_level_d = abs_val;
        sign_d      = coeff_ext[31];
        last_d      = coeff_last_i;
        esc_lvl_d   = lvl12;
      end else begin
        if (run_q != 6'd63) run_d = run_q + 6'd1;
        if (coeff_last_i) begin
          bits_d = EobBits;
          len_d  = EobLen;
        end
      end
    end

    if (state_q == StLookup) begin
      bits_d = vlc_escape_i ? esc_bits : vlc_bits;
      len_d  = vlc_escape_i ? 5'd24 : vlc_l + 5'd1;
    end

    if (out_fire) begin
      run_d = '0;
      if ((state_q == StEmit) && last_q) begin
        bits_d = EobBits;
        len_d  = EobLen;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= '0;
      vlc_run_q   <= '0;
      vlc_level_q <= '0;
      sign_q      <= 1'b0;
      last_q      <= 1'b0;
      esc_lvl_q   <= '0;
      bits_q      <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      run_q       <= run_d;
      vlc_run_q   <= vlc_run_d;
      vlc_level_q <= vlc_level_d;
      sign_q      <= sign_d;
      last_q      <= last_d;
      esc_lvl_q   <= esc_lvl_d;
      bits_q      <= bits_d;
      len_q       <= len_d;
      done_q      <= done_d;
    end
  end

  assign vlc_run_o    = vlc_run_q;
  assign vlc_level_o  = vlc_level_q;
  assign out_bits_o   = bits_q;
  assign out_len_o    = len_q;
  assign block_done_o = done_q;

endmodule

// File: tb/tb_dct_rle_encoder.sv
// Self-checking bench for dct_rle_encoder: directed vectors plus randomized blocks
// scored against a run-length/token reference model and a synthetic VLC table.
module tb_dct_rle_encoder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               coeff_valid, coeff_ready, coeff_last;
  logic signed [11:0] coeff;
  logic [5:0]         vlc_run;
  logic [15:0]        vlc_level, vlc_code;
  logic [3:0]         vlc_len;
  logic               vlc_escape;
  logic               out_valid, out_ready, block_done;
  logic [23:0]        out_bits;
  logic [4:0]         out_len;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        esc;
    logic [4:0]  len;
    logic [15:0] code;
  } vlc_t;

  typedef struct {
    int bits;
    int len;
    bit eob;
  } tok_t;

  int   blk[$];
  tok_t expq[$];
  vlc_t tbl;

  always #5 clk = ~clk;

  dct_rle_encoder #(.CoeffW(12)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .coeff_valid_i (coeff_valid),
    .coeff_ready_o (coeff_ready),
    .coeff_i       (coeff),
    .coeff_last_i  (coeff_last),
    .vlc_run_o     (vlc_run),
    .vlc_level_o   (vlc_level),
    .vlc_code_i    (vlc_code),
    .vlc_len_i     (vlc_len),
    .vlc_escape_i  (vlc_escape),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_bits_o    (out_bits),
    .out_len_o     (out_len),
    .block_done_o  (block_done)
  );

  // Synthetic table: a few fixed entries, hashed codes with junk above the length elsewhere
  function automatic vlc_t lookup(input int run, input int level);
    vlc_t e;
    e.esc = 1'b0;
    if (run == 0 && level == 1) begin
      e.code = 16'h0002; e.len = 5'd2;
    end else if (run == 2 && level == 1) begin
      e.code = 16'h0005; e.len = 5'd5;
    end else if (run == 1 && level == 15) begin
      e.code = 16'h0013; e.len = 5'd16;
    end else if ((run == 5 && level == 4) || level > 8 || run > 10 || level == 0) begin
      e.esc = 1'b1; e.code = 16'hffff; e.len = 5'd3;
    end else begin
      e.code = 16'(run * 40503 + level * 977 + 12345);
      e.len  = 5'(2 + (run * 3 + level) % 15);
    end
    return e;
  endfunction

  assign tbl        = lookup(int'(vlc_run), int'(vlc_level));
  assign vlc_code   = tbl.code;
  assign vlc_len    = tbl.len[3:0];
  assign vlc_escape = tbl.esc;

  function automatic tok_t mk(input int b, input int l, input bit e);
    tok_t t;
    t.bits = b; t.len = l; t.eob = e;
    return t;
  endfunction

  function automatic tok_t model_tok(input int run, input int c);
    vlc_t e;
    int   cl, l;
    e = lookup(run, (c < 0) ? -c : c);
    if (e.esc) begin
      cl = (c > 2047) ? 2047 : ((c < -2047) ? -2047 : c);
      return mk((1 << 18) | (run << 12) | (cl & 'hfff), 24, 1'b0);
    end
    l = int'(e.len);
    return mk(((int'(e.code) & ((1 << l) - 1)) << 1) | ((c < 0) ? 1 : 0), l + 1, 1'b0);
  endfunction

  task automatic model_block();
    int run = 0;
    expq.delete();
    foreach (blk[i]) begin
      if (blk[i] == 0) begin
        run = (run < 63) ? run + 1 : 63;
      end else begin
        expq.push_back(model_tok(run, blk[i]));
        run = 0;
      end
    end
    expq.push_back(mk(6, 4, 1'b1));
  endtask

  function automatic int rand_coeff();
    int r = int'($urandom_range(0, 99));
    int s = ($urandom_range(0, 1) == 1) ? -1 : 1;
    if (r < 60) return 0;
    if (r < 90) return s * int'($urandom_range(1, 8));
    if (r < 97) return s * int'($urandom_range(9, 300));
    return (r == 97) ? -2048 : ((r == 98) ? 2047 : -2047);
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 stall five cycles on each new token
  task automatic run_block(input string name, input int ready_mode, input bit gaps);
    int          idx = 0, cyc = 0, exp_valid_cyc = -1, stall_cnt = 0;
    bit          exp_done = 1'b0, pend_last = 1'b0, stalled = 1'b0, acc, fire;
    logic [23:0] held_bits;
    logic [4:0]  held_len;
    tok_t        e;
    while ((expq.size() > 0 || exp_done) && cyc < 3000) begin
      @(negedge clk);
      if (idx < blk.size()) begin
        coeff_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        coeff       = 12'(blk[idx]);
        coeff_last  = (idx == blk.size() - 1);
      end else begin
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      #1;
      tests++;
      if (block_done !== exp_done) begin
        fails++;
        $display("FAIL %s block_done cyc %0d: got %b want %b", name, cyc, block_done, exp_done);
      end
      exp_done = 1'b0;
      if (out_valid) begin
        tests++;
        if (coeff_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s ready_while_valid cyc %0d: coeff_ready=%b want 0", name, cyc,
                   coeff_ready);
        end
      end
      if (cyc == exp_valid_cyc) begin
        tests++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL %s latency cyc %0d: out_valid=%b want 1", name, cyc, out_valid);
        end
      end
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1 || out_bits !== held_bits || out_len !== held_len) begin
          fails++;
          $display("FAIL %s hold cyc %0d: got v=%b %h/%0d want v=1 %h/%0d", name, cyc,
                   out_valid, out_bits, out_len, held_bits, held_len);
        end
      end
      acc  = coeff_valid && coeff_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        stall_cnt = 0;
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL %s extra_token: got %h/%0d want none", name, out_bits, out_len);
        end else begin
          e = expq.pop_front();
          if (out_bits !== 24'(e.bits) || out_len !== 5'(e.len)) begin
            fails++;
            $display("FAIL %s token: got %h/%0d want %h/%0d", name, out_bits, out_len,
                     24'(e.bits), e.len);
          end
          if (e.eob) exp_done = 1'b1;
          else if (pend_last) begin
            exp_valid_cyc = cyc + 1;
            pend_last     = 1'b0;
          end
        end
      end
      stalled   = out_valid && !out_ready;
      held_bits = out_bits;
      held_len  = out_len;
      if (acc) begin
        if (blk[idx] != 0) begin
          exp_valid_cyc = cyc + 2;
          pend_last     = coeff_last;
        end else if (coeff_last) begin
          exp_valid_cyc = cyc + 1;
        end
        idx++;
      end
      cyc++;
    end
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL %s timeout: got %0d tokens outstanding want 0", name, expq.size());
    end
    @(negedge clk);
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if ({coeff_ready, out_valid, out_bits, out_len, vlc_run, vlc_level, block_done}
        !== {1'b1, 53'b0}) begin
      fails++;
      $display("FAIL %s: got rdy=%b v=%b bits=%h len=%0d run=%0d lvl=%0d done=%b want 1 0 0 0 0 0 0",
               name, coeff_ready, out_valid, out_bits, out_len, vlc_run, vlc_level, block_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coeff_valid = 1'b0; coeff = '0; coeff_last = 1'b0; out_ready = 1'b0;
    #2;
    check_reset_values("reset_values");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run62_eob();
    blk.delete();
    blk.push_back(1);
    repeat (63) blk.push_back(0);
    expq.delete();
    expq.push_back(mk(24'h4, 3, 1'b0));
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("run0_level1", 0, 1'b0);
  endtask

  task automatic test_neg_last();
    blk = '{0, 0, -1};
    expq.delete();
    expq.push_back(mk(24'h0b, 6, 1'b0));
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("neg_last", 0, 1'b0);
  endtask

  task automatic test_escape();
    blk = '{100, -100, 0, 15, 0, 0, 0, 0, 0, 4, -2048, 2047, 0};
    expq.delete();
    expq.push_back(mk(24'h040064, 24, 1'b0));
    expq.push_back(mk(24'h040f9c, 24, 1'b0));
    expq.push_back(mk(24'h000026, 17, 1'b0));
    expq.push_back(mk(24'h045004, 24, 1'b0));
    expq.push_back(mk(24'h040801, 24, 1'b0));
    expq.push_back(mk(24'h0407ff, 24, 1'b0));
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("escape", 0, 1'b0);
  endtask

  task automatic test_all_zero();
    blk.delete();
    repeat (64) blk.push_back(0);
    expq.delete();
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("all_zero", 0, 1'b0);
  endtask

  task automatic test_saturation();
    blk.delete();
    repeat (70) blk.push_back(0);
    blk.push_back(1);
    blk.push_back(0);
    expq.delete();
    expq.push_back(mk(24'h07f001, 24, 1'b0));
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("run_saturate", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    blk = '{0, 3, -2, 0, 0, 7, 0, 1};
    model_block();
    run_block("backpressure", 2, 1'b0);
  endtask

  task automatic test_reset_midblock();
    int idx = 0;
    for (int c = 0; c < 40 && out_valid !== 1'b1; c++) begin
      @(negedge clk);
      out_ready   = 1'b0;
      coeff_valid = (idx < 10);
      coeff       = (idx == 9) ? 12'sd3 : 12'sd0;
      coeff_last  = 1'b0;
      #1;
      if (coeff_valid && coeff_ready) idx++;
    end
    tests++;
    if (out_valid !== 1'b1 || idx != 10) begin
      fails++;
      $display("FAIL midblock_pending: got v=%b accepted=%0d want v=1 accepted=10", out_valid,
               idx);
    end
    rst_n = 1'b0;
    coeff_valid = 1'b0;
    #1;
    check_reset_values("midblock_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    blk = '{0, 0, -1};
    expq.delete();
    expq.push_back(mk(24'h0b, 6, 1'b0));
    expq.push_back(mk(24'h6, 4, 1'b1));
    run_block("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 40; b++) begin
      blk.delete();
      n = (b % 10 == 9) ? 80 : int'($urandom_range(1, 64));
      for (int i = 0; i < n; i++) blk.push_back(rand_coeff());
      model_block();
      run_block("random_block", b % 3, (b % 2) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_run62_eob();
    test_neg_last();
    test_escape();
    test_all_zero();
    test_saturation();
    test_backpressure();
    test_reset_midblock();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct_rle_encoder.md
# dct_rle_encoder

Run-length sequencer for the MPEG-2 intra AC coefficient path. It consumes quantized coefficients in zigzag order and counts zero runs. For each nonzero coefficient it drives the Table B.15 VLC lookup (dcthash) with (run, |level|) and emits a right-aligned bit token: VLC plus sign, or a 24-bit escape. It closes each block with the EOB code. It sits between the quantizer/zigzag stage and the bitstream packer.

## Interface
- COEFF_W, 12: signed coefficient width; escape level field is always 12 bits.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- coeff_valid  in  1  coefficient offered.
- coeff_ready  out  1  encoder accepts coefficient this cycle.
- coeff  in  COEFF_W  signed two's-complement coefficient.
- coeff_last  in  1  final coefficient of the block; qualifies with coeff_valid.
- vlc_run  out  6  registered run to the lookup table.
- vlc_level  out  16  registered |level|, zero-extended, to the lookup table.
- vlc_code  in  16  table code, right-aligned.
- vlc_len  in  4  table code length; 0 encodes 16.
- vlc_escape  in  1  table requests escape coding.
- out_valid  out  1  token valid.
- out_ready  in  1  packer accepts token.
- out_bits  out  24  token, right-aligned, MSB of token transmitted first.
- out_len  out  5  token length in bits (1..24).
- block_done  out  1  one-cycle pulse when EOB token is accepted.

## Operation
- FSM states: SCAN, LOOKUP, EMIT, EOB. Reset state is SCAN.
- SCAN:
  - coeff_ready=1. On a zero coefficient accepted: run <= run+1, saturating at 63. If coeff_last, go to EOB.
  - On a nonzero coefficient accepted: latch run, |coeff|, sign, and last flag; go to LOOKUP.
- LOOKUP: vlc_run/vlc_level are registered; the table result is combinational and is captured into the token register at the end of this cycle. Go to EMIT.
- Token formation:
  - Non-escape: out_bits = {vlc_code[L-1:0], sign}, out_len = L+1, where L = (vlc_len==0) ? 16 : vlc_len. sign is 0 for positive, 1 for negative.
  - Escape (vlc_escape=1): out_bits = {6'b000001, run[5:0], level12}, out_len = 24. level12 is the signed coefficient sign-extended or truncated to 12 bits. A coefficient of -2048 or below clamps to -2047; +2048 or above clamps to +2047.
- EMIT: out_valid=1. On out_ready: run <= 0, then go to EOB if the latched last flag is set, otherwise SCAN.
- EOB: out_valid=1, out_bits = 24'h000006 (code 0110), out_len = 4. On out_ready: block_done pulses, run <= 0, go to SCAN.
- Unused upper out_bits are 0.
- coeff_ready is 0 in LOOKUP, EMIT and EOB.

## Timing
- Reset values: state SCAN, run 0, coeff_ready 1, out_valid 0, out_bits 0, out_len 0, vlc_run 0, vlc_level 0, block_done 0.
- Zero coefficients are absorbed at 1 per cycle.
- A nonzero coefficient accepted at cycle t gives out_valid at t+2. With out_ready=1 the next coefficient is accepted at t+3. Minimum cost is 3 cycles per nonzero coefficient.
- A last coefficient that is zero, accepted at t, gives the EOB token valid at t+1.
- A last coefficient that is nonzero: EOB is valid on the cycle after the data token is accepted.
- Backpressure: while out_valid && !out_ready, out_bits and out_len are held stable and no input is accepted. out_valid never drops without a handshake.
- block_done is registered and is high in the cycle after the EOB handshake.
- Reset asserted mid-block: immediate return to reset values. The partial block is discarded and no EOB is emitted.
- Without coeff_last, run saturates at 63. The block is terminated only by coeff_last.

## Test plan
- Block of +1, then 62 zeros, then 0 with last → token 24'h4/len 3 (100), then 24'h6/len 4, then block_done one cycle later.
- 0, 0, -1 (last) → 24'h0B/len 6 (00101 then 1), then EOB.
- Run 0, level +100 → 24'h040064/len 24. Run 0, level -100 → 24'h040F9C/len 24.
- Run 1, level +15 (vlc_len=0) → 24'h000026/len 17. Run 5, level +4 (not in table) → 24'h045004/len 24.
- out_ready held low 5 cycles during EMIT → out_valid and token stable, coeff_ready=0, no coefficient dropped; the following coefficient's token is correct.
- 64 zeros with last → only the EOB token. Reset pulsed after 10 coefficients with a token pending → all outputs at reset values, and the next block encodes correctly from run 0.
